sdram_target: RTL

SDRAM_TARGET -- requirements
Module: sdram_target

---
 rtl/sdram_target.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/sdram_target.sv
// Behavioural SDRAM target: per-bank row tracking, CAS-latency read pipeline, backing memory.
// Protocol checking (err/err_code) is compiled in only when SDRAM_TARGET_CHECK_EN is defined.
module sdram_target #(
    parameter int MEM_AW  = 12,
    parameter int INIT_CL = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] addr,
    input  logic [1:0]  ba,
    input  logic        ras_n,
    input  logic        cas_n,
    input  logic        we_n,
    inout  wire  [15:0] dq,
    output logic        err,
    output logic [2:0]  err_code
);

`ifdef SDRAM_TARGET_CHECK_EN
    localparam logic CHECK_EN = 1'b1;
`else
    localparam logic CHECK_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        CMD_LOAD_MODE = 3'b000,
        CMD_REFRESH   = 3'b001,
        CMD_PRECHARGE = 3'b010,
        CMD_ACTIVE    = 3'b011,
        CMD_WRITE     = 3'b100,
        CMD_READ      = 3'b101,
        CMD_NOP       = 3'b111
    } cmd_e;

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } bank_state_e;

    bank_state_e         bank_q [4];
    bank_state_e         bank_d [4];
    logic [12:0]         row_q [4];
    logic [12:0]         row_d [4];
    logic [2:0]          cl_q, cl_d;
    logic [2:0]          pipe_vld_q, pipe_vld_d;
    logic [15:0]         pipe_dat_q [3];
    logic [15:0]         pipe_dat_d [3];
    logic                dq_oe_q, dq_oe_d;
    logic [15:0]         dq_out_q, dq_out_d;
    logic                err_q, err_d;
    logic [2:0]          err_code_q, err_code_d;

    logic [15:0]         mem [2**MEM_AW];
    cmd_e                cmd_s;
    logic [MEM_AW-1:0]   mem_idx_s;
    logic                mem_we_s;
    logic                rd_s;
    logic                bank_open_s;
    logic                any_open_s;

    // Command decode, bank state machines, mode register and error capture.
    always_comb begin
        cmd_s       = rst ? CMD_NOP : cmd_e'({ras_n, cas_n, we_n});
        mem_idx_s   = MEM_AW'({ba, row_q[ba], addr[9:0]});
        bank_open_s = (bank_q[ba] == OPEN);
        any_open_s  = (bank_q[0] == OPEN) || (bank_q[1] == OPEN) ||
                      (bank_q[2] == OPEN) || (bank_q[3] == OPEN);
        bank_d      = bank_q;
        row_d       = row_q;
        cl_d        = cl_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        mem_we_s    = 1'b0;
        rd_s        = 1'b0;
        case (cmd_s)
            CMD_ACTIVE: begin
                if (CHECK_EN && bank_open_s) begin
                    err_d      = 1'b1;
                    err_code_d = 3'd2;
                end else begin
                    bank_d[ba] = OPEN;
                    row_d[ba]  = addr;
                end
            end
            CMD_READ: begin
                if (CHECK_EN && !bank_open_s) begin
                    err_d      = 1'b1;
                    err_code_d = 3'd1;
                end else begin
                    rd_s = 1'b1;
                end
            end
            CMD_WRITE: begin
                if (CHECK_EN && !bank_open_s) begin
                    err_d      = 1'b1;
                    err_code_d = 3'd1;
                end else if (dq_oe_q) begin
                    // We are driving a read beat at this edge, so the write data is unusable.
                    err_d      = err_q | CHECK_EN;
                    err_code_d = CHECK_EN ? 3'd4 : err_code_q;
                end else begin
                    mem_we_s = 1'b1;
                end
            end
            CMD_PRECHARGE: begin
                if (addr[10]) begin
                    for (int i = 0; i < 4; i++) bank_d[i] = IDLE;
                end else begin
                    bank_d[ba] = IDLE;
                end
            end
            CMD_REFRESH: begin
                if (CHECK_EN && any_open_s) begin
                    err_d      = 1'b1;
                    err_code_d = 3'd3;
                end else begin
                    err_d = err_q;
                end
            end
            CMD_LOAD_MODE: begin
                if (CHECK_EN && any_open_s) begin
                    err_d      = 1'b1;
                    err_code_d = 3'd3;
                end else if ((addr[6:4] == 3'd2) || (addr[6:4] == 3'd3)) begin
                    cl_d = addr[6:4];
                end else if (CHECK_EN) begin
                    err_d      = 1'b1;
                    err_code_d = 3'd5;
                end else begin
                    cl_d = cl_q;
                end
            end
            default: begin
                err_d = err_q;
            end
        endcase
    end

    // Read pipeline: a read enters at the slot matching the CL in force when it was issued.
    always_comb begin
        pipe_vld_d    = {1'b0, pipe_vld_q[2:1]};
        pipe_dat_d[0] = pipe_dat_q[1];
        pipe_dat_d[1] = pipe_dat_q[2];
        pipe_dat_d[2] = 16'h0000;
        if (rd_s) begin
            if (cl_q == 3'd3) begin
                pipe_vld_d[2] = 1'b1;
                pipe_dat_d[2] = mem[mem_idx_s];
            end else begin
                pipe_vld_d[1] = 1'b1;
                pipe_dat_d[1] = mem[mem_idx_s];
            end
        end else begin
            pipe_vld_d[2] = 1'b0;
        end
        dq_oe_d  = pipe_vld_q[0];
        dq_out_d = pipe_dat_q[0];
    end

    // State registers; memory is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                bank_q[i] <= IDLE;
                row_q[i]  <= 13'd0;
            end
            for (int i = 0; i < 3; i++) pipe_dat_q[i] <= 16'h0000;
            cl_q       <= 3'(INIT_CL);
            pipe_vld_q <= 3'b000;
            dq_oe_q    <= 1'b0;
            dq_out_q   <= 16'h0000;
            err_q      <= 1'b0;
            err_code_q <= 3'd0;
        end else begin
            bank_q     <= bank_d;
            row_q      <= row_d;
            pipe_dat_q <= pipe_dat_d;
            cl_q       <= cl_d;
            pipe_vld_q <= pipe_vld_d;
            dq_oe_q    <= dq_oe_d;
            dq_out_q   <= dq_out_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // Backing memory write port; dq is sampled at the WRITE command edge.
    always_ff @(posedge clk) begin
        if (mem_we_s) mem[mem_idx_s] <= dq;
    end

    assign dq       = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign err      = err_q & CHECK_EN;
    assign err_code = CHECK_EN ? err_code_q : 3'd0;

endmodule
